// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with valid/ready handshake and a
// one-entry skid buffer. The head entry drives the outputs. The skid entry
// absorbs the one extra word that upstream may push in the cycle that
// downstream stalls. in_ready depends only on registered state and reset,
// so there is no combinational path from out_ready to in_ready. Control is
// presented as zero (a NOP) whenever the stage holds a bubble.
module pipe_stage_reg #(
  parameter int DATA_W              = 32,
  parameter int CTRL_W              = 8,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_cycles
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_main_data;
  logic [DATA_W-1:0]   w_main_data_nxt;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [CTRL_W-1:0]   w_main_ctrl_nxt;
  logic [DATA_W-1:0]   r_skid_data;
  logic [DATA_W-1:0]   w_skid_data_nxt;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [CTRL_W-1:0]   w_skid_ctrl_nxt;
  logic [15:0]         r_stall_cnt;
  logic                w_accept;
  logic                w_consume;
  logic                w_stall_evt;

  // Counter that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  assign in_ready     = reset & (r_state != ST_FULL);
  assign out_valid    = (r_state != ST_EMPTY);
  assign out_data     = r_main_data;
  assign out_ctrl     = out_valid ? r_main_ctrl : {CTRL_W{1'b0}};
  assign occupancy    = r_state;
  assign stall_cycles = r_stall_cnt;

  assign w_accept    = in_valid & in_ready;
  assign w_consume   = out_valid & out_ready;
  assign w_stall_evt = reset & ~flush & in_valid & ~in_ready;

  // Next-state and entry-update logic; flush overrides every handshake.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_data_nxt = r_main_data;
    w_main_ctrl_nxt = r_main_ctrl;
    w_skid_data_nxt = r_skid_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    if (flush) begin
      w_state_nxt     = ST_EMPTY;
      w_main_ctrl_nxt = {CTRL_W{1'b0}};
      w_skid_ctrl_nxt = {CTRL_W{1'b0}};
      if (CLEAR_DATA_ON_FLUSH) begin
        w_main_data_nxt = {DATA_W{1'b0}};
        w_skid_data_nxt = {DATA_W{1'b0}};
      end else begin
        w_main_data_nxt = r_main_data;
        w_skid_data_nxt = r_skid_data;
      end
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt     = ST_ONE;
            w_main_data_nxt = in_data;
            w_main_ctrl_nxt = in_ctrl;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (w_accept && w_consume) begin
            w_state_nxt     = ST_ONE;
            w_main_data_nxt = in_data;
            w_main_ctrl_nxt = in_ctrl;
          end else if (w_accept) begin
            w_state_nxt     = ST_FULL;
            w_skid_data_nxt = in_data;
            w_skid_ctrl_nxt = in_ctrl;
          end else if (w_consume) begin
            // Drained: leave a NOP behind in the head control field.
            w_state_nxt     = ST_EMPTY;
            w_main_ctrl_nxt = {CTRL_W{1'b0}};
          end else begin
            w_state_nxt = ST_ONE;
          end
        end
        ST_FULL: begin
          if (w_consume) begin
            w_state_nxt     = ST_ONE;
            w_main_data_nxt = r_skid_data;
            w_main_ctrl_nxt = r_skid_ctrl;
            w_skid_data_nxt = {DATA_W{1'b0}};
            w_skid_ctrl_nxt = {CTRL_W{1'b0}};
          end else begin
            w_state_nxt = ST_FULL;
          end
        end
        default: begin
          w_state_nxt     = ST_EMPTY;
          w_main_ctrl_nxt = {CTRL_W{1'b0}};
          w_skid_ctrl_nxt = {CTRL_W{1'b0}};
        end
      endcase
    end
  end

  // State, entry and stall-counter registers; reset beats flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_EMPTY;
      r_main_data <= {DATA_W{1'b0}};
      r_main_ctrl <= {CTRL_W{1'b0}};
      r_skid_data <= {DATA_W{1'b0}};
      r_skid_ctrl <= {CTRL_W{1'b0}};
      r_stall_cnt <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_main_data <= w_main_data_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      if (w_stall_evt) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: table-driven directed vectors and hand-written
// flush/saturation/reset sequences on 32/8 instances (data-clearing and
// data-retaining flush), plus a random handshake soak on a 64/3 instance
// checked against a queue-based reference model.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two 32/8 instances.
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_out_data, b_out_data;
  logic [7:0]  a_out_ctrl, b_out_ctrl;
  logic [1:0]  a_occ, b_occ;
  logic [15:0] a_stall, b_stall;

  // Soak instance stimulus/outputs.
  logic        c_flush, c_in_valid, c_out_ready, c_in_ready, c_out_valid;
  logic [63:0] c_in_data, c_out_data;
  logic [2:0]  c_in_ctrl, c_out_ctrl;
  logic [1:0]  c_occ;
  logic [15:0] c_stall;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CLEAR_DATA_ON_FLUSH(1'b1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_ctrl(a_out_ctrl), .occupancy(a_occ), .stall_cycles(a_stall));

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CLEAR_DATA_ON_FLUSH(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_ctrl(b_out_ctrl), .occupancy(b_occ), .stall_cycles(b_stall));

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(3), .CLEAR_DATA_ON_FLUSH(1'b1)) dut_c (
    .clk(clk), .reset(reset), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_ctrl(c_in_ctrl), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_ctrl(c_out_ctrl), .occupancy(c_occ), .stall_cycles(c_stall));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rst_n;
    logic        fl;
    logic        iv;
    logic [31:0] id;
    logic [7:0]  ic;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic        e_chkd;
    logic [31:0] e_od;
    logic [7:0]  e_oc;
    logic [1:0]  e_occ;
    logic [15:0] e_st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst_n, input logic fl, input logic iv,
                              input logic [31:0] id, input logic [7:0] ic, input logic ordy,
                              input logic e_ir, input logic e_ov, input logic e_chkd,
                              input logic [31:0] e_od, input logic [7:0] e_oc,
                              input logic [1:0] e_occ, input logic [15:0] e_st);
    vec_t v;
    v.rst_n = rst_n; v.fl = fl; v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_chkd = e_chkd; v.e_od = e_od; v.e_oc = e_oc;
    v.e_occ = e_occ; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic fl, input logic iv,
                       input logic [31:0] id, input logic [7:0] ic, input logic ordy);
    reset = rst_n; flush = fl; in_valid = iv; in_data = id; in_ctrl = ic; out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Soak reference model: FIFO of {data, ctrl} words, capacity two.
  logic [66:0] cq[$];
  logic [15:0] c_st_exp;

  initial begin
    c_flush = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_data = 64'd0; c_in_ctrl = 3'd0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b1);

    // Directed table: reset, stream, back-pressure into the skid entry.
    tbl.push_back(mk(1'b0,1'b0,1'b0,32'd0,8'h00,1'b1, 1'b0,1'b0,1'b1,32'd0,8'h00,2'd0,16'd0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,32'd99,8'h5A,1'b1, 1'b0,1'b0,1'b1,32'd0,8'h00,2'd0,16'd0));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(1'b1,1'b0,1'b1,32'(k),8'hA5,1'b1, 1'b1,1'b1,1'b1,32'(k),8'hA5,2'd1,16'd0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,32'd0,8'h00,1'b1, 1'b1,1'b0,1'b0,32'd0,8'h00,2'd0,16'd0));
    tbl.push_back(mk(1'b1,1'b0,1'b1,32'd10,8'h11,1'b0, 1'b1,1'b1,1'b1,32'd10,8'h11,2'd1,16'd0));
    tbl.push_back(mk(1'b1,1'b0,1'b1,32'd11,8'h22,1'b0, 1'b0,1'b1,1'b1,32'd10,8'h11,2'd2,16'd0));
    tbl.push_back(mk(1'b1,1'b0,1'b1,32'd12,8'h33,1'b0, 1'b0,1'b1,1'b1,32'd10,8'h11,2'd2,16'd1));
    tbl.push_back(mk(1'b1,1'b0,1'b1,32'd12,8'h33,1'b0, 1'b0,1'b1,1'b1,32'd10,8'h11,2'd2,16'd2));
    tbl.push_back(mk(1'b1,1'b0,1'b1,32'd12,8'h33,1'b1, 1'b1,1'b1,1'b1,32'd11,8'h22,2'd1,16'd3));
    tbl.push_back(mk(1'b1,1'b0,1'b1,32'd12,8'h33,1'b1, 1'b1,1'b1,1'b1,32'd12,8'h33,2'd1,16'd3));
    tbl.push_back(mk(1'b1,1'b0,1'b0,32'd0,8'h00,1'b1, 1'b1,1'b0,1'b0,32'd0,8'h00,2'd0,16'd3));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].fl, tbl[i].iv, tbl[i].id, tbl[i].ic, tbl[i].ordy);
      step();
      chk($sformatf("v%0d in_ready", i), 64'(a_in_ready), 64'(tbl[i].e_ir));
      chk($sformatf("v%0d out_valid", i), 64'(a_out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("v%0d out_ctrl", i), 64'(a_out_ctrl), 64'(tbl[i].e_oc));
      chk($sformatf("v%0d occupancy", i), 64'(a_occ), 64'(tbl[i].e_occ));
      chk($sformatf("v%0d stall", i), 64'(a_stall), 64'(tbl[i].e_st));
      if (tbl[i].e_chkd)
        chk($sformatf("v%0d out_data", i), 64'(a_out_data), 64'(tbl[i].e_od));
    end

    // Flush in FULL, with a blocked word offered in the flush cycle.
    drive(1'b1, 1'b0, 1'b1, 32'd30, 8'hFF, 1'b0); step();
    drive(1'b1, 1'b0, 1'b1, 32'd31, 8'hFF, 1'b0); step();
    chk("fullb4flush occ", 64'(a_occ), 64'd2);
    chk("fullb4flush in_ready", 64'(a_in_ready), 64'd0);
    drive(1'b1, 1'b1, 1'b1, 32'd32, 8'hFF, 1'b0); step();
    chk("flushfull out_valid", 64'(a_out_valid), 64'd0);
    chk("flushfull out_ctrl", 64'(a_out_ctrl), 64'd0);
    chk("flushfull occ", 64'(a_occ), 64'd0);
    chk("flushfull out_data clr", 64'(a_out_data), 64'd0);
    chk("flushfull in_ready", 64'(a_in_ready), 64'd1);
    chk("flushfull stall kept", 64'(a_stall), 64'd3);
    chk("flushfull keep out_data", 64'(b_out_data), 64'd30);
    chk("flushfull keep out_ctrl", 64'(b_out_ctrl), 64'd0);
    chk("flushfull keep occ", 64'(b_occ), 64'd0);

    // Flush coincident with accept and consume.
    drive(1'b1, 1'b0, 1'b1, 32'd20, 8'h44, 1'b0); step();
    chk("one20 out_data", 64'(a_out_data), 64'd20);
    drive(1'b1, 1'b1, 1'b1, 32'd21, 8'h55, 1'b1);
    #1;
    chk("coinc consumed valid", 64'(a_out_valid), 64'd1);
    chk("coinc consumed data", 64'(a_out_data), 64'd20);
    step();
    chk("coinc out_valid", 64'(a_out_valid), 64'd0);
    chk("coinc occ", 64'(a_occ), 64'd0);
    chk("coinc out_ctrl", 64'(a_out_ctrl), 64'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 8'h00, 1'b1); step();
    chk("coinc 21 dropped", 64'(a_out_valid), 64'd0);

    // Stall counter saturation, then reset together with flush.
    drive(1'b1, 1'b0, 1'b1, 32'd40, 8'h66, 1'b0); step();
    drive(1'b1, 1'b0, 1'b1, 32'd41, 8'h67, 1'b0); step();
    chk("sat full occ", 64'(a_occ), 64'd2);
    drive(1'b1, 1'b0, 1'b1, 32'd42, 8'h77, 1'b0);
    repeat (65531) step();
    chk("sat stall FFFE", 64'(a_stall), 64'hFFFE);
    step();
    chk("sat stall FFFF", 64'(a_stall), 64'hFFFF);
    repeat (70000 - 65532) step();
    chk("sat stall hold", 64'(a_stall), 64'hFFFF);
    chk("sat occ", 64'(a_occ), 64'd2);
    chk("sat head", 64'(a_out_data), 64'd40);
    drive(1'b0, 1'b1, 1'b1, 32'd43, 8'h88, 1'b1); step();
    chk("rst out_valid", 64'(a_out_valid), 64'd0);
    chk("rst out_data", 64'(a_out_data), 64'd0);
    chk("rst out_ctrl", 64'(a_out_ctrl), 64'd0);
    chk("rst occ", 64'(a_occ), 64'd0);
    chk("rst stall", 64'(a_stall), 64'd0);
    chk("rst in_ready low", 64'(a_in_ready), 64'd0);
    chk("rst keep-variant data", 64'(b_out_data), 64'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 8'h00, 1'b0);
    #1;
    chk("rst release in_ready", 64'(a_in_ready), 64'd1);
    step();
    chk("post rst in_ready", 64'(a_in_ready), 64'd1);

    // Random handshake soak on the 64/3 instance.
    c_st_exp = 16'd0;
    begin
      int pv, pr;
      pv = 2; pr = 2;
      for (int cyc = 0; cyc < 10000; cyc++) begin
        logic acc, cons, iv, fl;
        logic [63:0] d;
        logic [2:0] c;
        if (cyc % 500 == 0) begin
          pv = $urandom_range(1, 4);
          pr = $urandom_range(1, 4);
        end
        iv = ($urandom_range(0, 4) < pv);
        fl = ($urandom_range(0, 99) == 0);
        d = {$urandom, $urandom};
        c = 3'($urandom_range(0, 7));
        c_in_valid = iv; c_in_data = d; c_in_ctrl = c; c_flush = fl;
        c_out_ready = ($urandom_range(0, 4) < pr);
        acc = iv && (cq.size() < 2);
        cons = (cq.size() > 0) && c_out_ready;
        step();
        if (fl) begin
          cq.delete();
        end else begin
          if (iv && cq.size() == 2 && c_st_exp != 16'hFFFF) c_st_exp = c_st_exp + 16'd1;
          if (cons) void'(cq.pop_front());
          if (acc) cq.push_back({d, c});
        end
        chk("soak out_valid", 64'(c_out_valid), 64'(cq.size() > 0));
        chk("soak occupancy", 64'(c_occ), 64'(cq.size()));
        chk("soak in_ready", 64'(c_in_ready), 64'(cq.size() < 2));
        chk("soak stall", 64'(c_stall), 64'(c_st_exp));
        if (cq.size() > 0) begin
          chk("soak out_data", c_out_data, cq[0][66:3]);
          chk("soak out_ctrl", 64'(c_out_ctrl), 64'(cq[0][2:0]));
        end else begin
          chk("soak bubble ctrl", 64'(c_out_ctrl), 64'd0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
